// File: rtl/melody_sequencer_if.sv
// Control and tone-divider signals between the user-control side and the melody sequencer.
interface melody_sequencer_if;
  logic        start;
  logic        stop;
  logic        loop;
  logic [27:0] note_divisor;
  logic        tone_en;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (output start, stop, loop,
                  input  note_divisor, tone_en, note_idx, busy, done);
  modport slave  (input  start, stop, loop,
                  output note_divisor, tone_en, note_idx, busy, done);
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a 16-entry song ROM, driving one programmable tone divider with
// per-note divisor/enable for a beat-timed window followed by a short silent gap.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | fetch ROM entry note_idx, program divider and timer
// PLAY    | tone window, timer counting down
// GAP     | silent tail of the entry, timer counting down
// DONE    | one-cycle end-of-song pulse
module melody_sequencer #(
  parameter logic [27:0] BEAT_TICKS = 28'd12_500_000,
  parameter logic [27:0] GAP_TICKS  = 28'd1_250_000
) (
  input  logic              clock_in,
  input  logic              rst_n,
  melody_sequencer_if.slave bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [27:0] note_divisor_q, note_divisor_d;
  logic        tone_en_q, tone_en_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  entry;
  logic [3:0]  entry_note;
  logic [3:0]  entry_beats;

  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1:   rom_entry = {4'd1, 4'd1};
      4'd2, 4'd3:   rom_entry = {4'd5, 4'd1};
      4'd4, 4'd5:   rom_entry = {4'd6, 4'd1};
      4'd6:         rom_entry = {4'd5, 4'd2};
      4'd7, 4'd8:   rom_entry = {4'd4, 4'd1};
      4'd9, 4'd10:  rom_entry = {4'd3, 4'd1};
      4'd11, 4'd12: rom_entry = {4'd2, 4'd1};
      4'd13:        rom_entry = {4'd1, 4'd2};
      4'd14:        rom_entry = {4'd0, 4'd2};
      default:      rom_entry = {4'd0, 4'd0};
    endcase
  endfunction

  function automatic logic [27:0] code_divisor(input logic [3:0] code);
    case (code)
      4'd1:    code_divisor = 28'd190840;
      4'd2:    code_divisor = 28'd170068;
      4'd3:    code_divisor = 28'd151745;
      4'd4:    code_divisor = 28'd143266;
      4'd5:    code_divisor = 28'd127551;
      4'd6:    code_divisor = 28'd113636;
      4'd7:    code_divisor = 28'd101239;
      4'd8:    code_divisor = 28'd95420;
      default: code_divisor = 28'd0;
    endcase
  endfunction

  assign entry       = rom_entry(note_idx_q);
  assign entry_note  = entry[7:4];
  assign entry_beats = entry[3:0];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    note_divisor_d = note_divisor_q;
    tone_en_d      = tone_en_q;
    note_idx_d     = note_idx_q;
    done_d         = 1'b0;

    if (state_q != ST_IDLE && bus.stop) begin
      state_d        = ST_IDLE;
      cnt_d          = 32'd0;
      note_divisor_d = 28'd0;
      tone_en_d      = 1'b0;
      note_idx_d     = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d    = ST_LOAD;
            note_idx_d = 4'd0;
          end
        end
        ST_LOAD: begin
          if (entry_beats == 4'd0) begin
            if (bus.loop) begin
              note_idx_d = 4'd0;
            end else begin
              state_d        = ST_DONE;
              done_d         = 1'b1;
              note_divisor_d = 28'd0;
              tone_en_d      = 1'b0;
            end
          end else begin
            // Timer spans the tone window only; GAP supplies the remaining silent cycles.
            note_divisor_d = code_divisor(entry_note);
            tone_en_d      = (entry_note != 4'd0) && (entry_note <= 4'd8);
            cnt_d          = 32'(entry_beats) * 32'(BEAT_TICKS) - 32'(GAP_TICKS) - 32'd1;
            state_d        = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (cnt_q == 32'd0) begin
            state_d   = ST_GAP;
            tone_en_d = 1'b0;
            cnt_d     = 32'(GAP_TICKS) - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 32'd0) begin
            state_d    = ST_LOAD;
            note_idx_d = note_idx_q + 4'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 32'd0;
      note_divisor_q <= 28'd0;
      tone_en_q      <= 1'b0;
      note_idx_q     <= 4'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      note_divisor_q <= note_divisor_d;
      tone_en_q      <= tone_en_d;
      note_idx_q     <= note_idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.note_divisor = note_divisor_q;
  assign bus.tone_en      = tone_en_q;
  assign bus.note_idx     = note_idx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: cycle-by-cycle comparison against a song-timeline model
// derived from the ROM table and beat arithmetic, with randomized control stimulus.
module tb_melody_sequencer;

  localparam logic [27:0] BT = 28'd10;
  localparam logic [27:0] GT = 28'd2;

  typedef struct packed {
    logic [27:0] div;
    logic        ten;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } exp_t;

  logic clock_in = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  int note_tab [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
  int beat_tab [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 2, 0};
  int div_tab  [16] = '{0, 190840, 170068, 151745, 143266, 127551, 113636, 101239,
                        95420, 0, 0, 0, 0, 0, 0, 0};

  always #5 clock_in = ~clock_in;

  melody_sequencer_if bus();

  melody_sequencer #(.BEAT_TICKS(BT), .GAP_TICKS(GT)) dut (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  // Expected outputs t edges after the edge that accepted start (t=0 is entry 0 LOAD).
  function automatic exp_t model(input int t, input bit lp);
    exp_t e;
    int   pos  = t;
    int   idx  = 0;
    int   prev = 0;
    int   b, c, len;
    e = '0;
    for (int guard = 0; guard < 2000; guard++) begin
      b = beat_tab[idx];
      c = note_tab[idx];
      if (b == 0) begin
        if (pos == 0) begin
          e = '{28'(prev), 1'b0, 4'(idx), 1'b1, 1'b0};
          return e;
        end
        if (!lp) begin
          if (pos == 1) e = '{28'd0, 1'b0, 4'(idx), 1'b1, 1'b1};
          else          e = '{28'd0, 1'b0, 4'(idx), 1'b0, 1'b0};
          return e;
        end
        pos = pos - 1;
        idx = 0;
      end else begin
        len = 1 + b * int'(BT);
        if (pos < len) begin
          if (pos == 0)
            e = '{28'(prev), 1'b0, 4'(idx), 1'b1, 1'b0};
          else if (pos <= b * int'(BT) - int'(GT))
            e = '{28'(div_tab[c]), (c >= 1 && c <= 8), 4'(idx), 1'b1, 1'b0};
          else
            e = '{28'(div_tab[c]), 1'b0, 4'(idx), 1'b1, 1'b0};
          return e;
        end
        pos  = pos - len;
        prev = div_tab[c];
        idx  = idx + 1;
      end
    end
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o = '{bus.note_divisor, bus.tone_en, bus.note_idx, bus.busy, bus.done};
    return o;
  endfunction

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic halt();
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    tick();
    bus.stop  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      o = obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp all zero",
                 i, o.div, o.ten, o.idx, o.busy, o.done);
      end
      tick();
    end
  endtask

  task automatic test_first_note();
    exp_t o, e;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      o = obs();
      e = model(t, 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL first_note t=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp div=%0d ten=%0b idx=%0d busy=%0b done=%0b",
                 t, o.div, o.ten, o.idx, o.busy, o.done, e.div, e.ten, e.idx, e.busy, e.done);
      end
      if (t == 1) begin
        checks++;
        if (o.div !== 28'd190840 || o.ten !== 1'b1) begin
          errors++;
          $display("FAIL first_note_do got div=%0d ten=%0b exp div=190840 ten=1", o.div, o.ten);
        end
      end
      if (t == 11) begin
        checks++;
        if (o.idx !== 4'd1) begin
          errors++;
          $display("FAIL first_note_idx got idx=%0d exp idx=1", o.idx);
        end
      end
      tick();
    end
    halt();
  endtask

  task automatic test_full_song();
    exp_t o, e;
    int   sol_on = 0;
    int   rest_quiet = 0;
    int   done_cnt = 0;
    int   done_t = -1;
    bus.loop  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= 205; t++) begin
      o = obs();
      e = model(t, 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_song t=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp div=%0d ten=%0b idx=%0d busy=%0b done=%0b",
                 t, o.div, o.ten, o.idx, o.busy, o.done, e.div, e.ten, e.idx, e.busy, e.done);
      end
      if (o.idx == 4'd6 && o.ten) sol_on++;
      if (o.idx == 4'd14 && o.div == 28'd0 && !o.ten) rest_quiet++;
      if (o.done) begin
        done_cnt++;
        done_t = t;
      end
      bus.start = (t < 190) && ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (sol_on != 18) begin
      errors++;
      $display("FAIL sol_tone_cycles got %0d exp 18", sol_on);
    end
    checks++;
    if (rest_quiet != 20) begin
      errors++;
      $display("FAIL rest_quiet_cycles got %0d exp 20", rest_quiet);
    end
    checks++;
    if (done_cnt != 1 || done_t != 196) begin
      errors++;
      $display("FAIL done_pulse got count=%0d at t=%0d exp count=1 at t=196", done_cnt, done_t);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %0b exp 0", bus.busy);
    end
  endtask

  task automatic test_loop();
    exp_t o, e;
    int   done_cnt = 0;
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= 2 * 196 + 15; t++) begin
      o = obs();
      e = model(t, 1'b1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL loop t=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp div=%0d ten=%0b idx=%0d busy=%0b done=%0b",
                 t, o.div, o.ten, o.idx, o.busy, o.done, e.div, e.ten, e.idx, e.busy, e.done);
      end
      if (o.done) done_cnt++;
      if (t == 197) begin
        checks++;
        if (o.idx !== 4'd0 || o.div !== 28'd190840) begin
          errors++;
          $display("FAIL loop_restart got idx=%0d div=%0d exp idx=0 div=190840", o.idx, o.div);
        end
      end
      tick();
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL loop_no_done got %0d pulses exp 0", done_cnt);
    end
    bus.loop = 1'b0;
    halt();
  endtask

  task automatic test_stop_mid();
    exp_t o, e;
    int   stop_t;
    stop_t = 34 + int'($urandom_range(0, 7));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= stop_t; t++) begin
      o = obs();
      e = model(t, 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_pre t=%0d got div=%0d ten=%0b idx=%0d exp div=%0d ten=%0b idx=%0d",
                 t, o.div, o.ten, o.idx, e.div, e.ten, e.idx);
      end
      if (t < stop_t) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o = obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL stop_idle cyc=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp all zero",
                 i, o.div, o.ten, o.idx, o.busy, o.done);
      end
      tick();
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= 23; t++) begin
      o = obs();
      e = model(t, 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL restart t=%0d got div=%0d ten=%0b idx=%0d exp div=%0d ten=%0b idx=%0d",
                 t, o.div, o.ten, o.idx, e.div, e.ten, e.idx);
      end
      tick();
    end
    halt();
  endtask

  task automatic test_start_stop_idle();
    exp_t o;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      o = obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL start_stop_idle cyc=%0d got div=%0d ten=%0b idx=%0d busy=%0b exp all zero",
                 i, o.div, o.ten, o.idx, o.busy);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t o;
    int   n;
    n = int'($urandom_range(2, 60));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (n) tick();
    rst_n = 1'b0;
    tick();
    o = obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid after=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp all zero",
               n, o.div, o.ten, o.idx, o.busy, o.done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random_runs();
    exp_t o, e;
    bit   lp;
    int   len;
    for (int r = 0; r < 3; r++) begin
      lp  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(40, 420));
      if (!lp && len > 190) len = 190;
      bus.loop  = lp;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int t = 0; t <= len; t++) begin
        o = obs();
        e = model(t, lp);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random run=%0d loop=%0b t=%0d got div=%0d ten=%0b idx=%0d busy=%0b done=%0b exp div=%0d ten=%0b idx=%0d busy=%0b done=%0b",
                   r, lp, t, o.div, o.ten, o.idx, o.busy, o.done, e.div, e.ten, e.idx, e.busy, e.done);
        end
        bus.start = 1'($urandom_range(0, 1));
        tick();
      end
      halt();
      bus.loop = 1'b0;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    test_reset();
    test_first_note();
    test_full_song();
    test_loop();
    test_stop_mid();
    test_start_stop_idle();
    test_reset_mid();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a fixed 16-entry song ROM by reprogramming a downstream programmable tone divider.
- For each note it presents the divisor and a tone-enable for a timed number of beats, with a short silent gap between notes.
- Sits between the user controls (start/stop/loop buttons) and the note divider. It replaces the fixed per-note divider modules with a single sequenced resource.

Parameters:
- BEAT_TICKS, 28'd12_500_000, clock cycles per beat (250 ms at 50 MHz).
- GAP_TICKS, 28'd1_250_000, silent cycles at the end of every entry. Must be < BEAT_TICKS.

Ports:
- clock_in  input  1  system clock (50 MHz)
- rst_n  input  1  synchronous reset, active-low
- start  input  1  level, sampled each cycle; begins playback when idle
- stop  input  1  level; aborts playback
- loop  input  1  when 1, the song restarts at entry 0 instead of finishing
- note_divisor  output  28  divisor for the tone divider; 0 = silence
- tone_en  output  1  tone divider output enable
- note_idx  output  4  ROM entry currently playing
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at the natural end of the song

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset. All outputs are registered. On reset: state=IDLE, note_idx=0, note_divisor=0, tone_en=0, busy=0, done=0, beat counter=0.
- ROM entry format: {note[3:0], beats[3:0]}. beats=0 is the end marker.
- Note divisor codes:
  - 1 do 190840
  - 2 re 170068
  - 3 mi 151745
  - 4 fa 143266
  - 5 sol 127551
  - 6 la 113636
  - 7 si 101239
  - 8 do_alto 95420
  - 0 and 9-15: rest (divisor 0, tone_en 0)
- ROM contents:
  - Entries 0-13: 1/1, 1/1, 5/1, 5/1, 6/1, 6/1, 5/2, 4/1, 4/1, 3/1, 3/1, 2/1, 2/1, 1/2
  - Entry 14: 0/2 (rest)
  - Entry 15: 0/0 (end marker)
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: if start=1 and stop=0, go to LOAD next cycle with note_idx=0.
- LOAD (1 cycle): read entry note_idx.
  - If beats=0 and loop=0: go to DONE.
  - If beats=0 and loop=1: note_idx<=0, stay in LOAD.
  - Otherwise: register note_divisor, set tone_en = (code is 1..8), load the counter with beats*BEAT_TICKS-GAP_TICKS-1, go to PLAY.
- PLAY: count down to 0, then go to GAP with tone_en<=0 (note_divisor is held) and counter<=GAP_TICKS-1.
- GAP: count down to 0, then note_idx<=note_idx+1 (4-bit wrap), go to LOAD.
- Entry timing: each entry lasts exactly 1 + beats*BEAT_TICKS cycles. Of these, tone_en is high for beats*BEAT_TICKS-GAP_TICKS cycles.
- DONE: done=1 for exactly 1 cycle, note_divisor<=0, then go to IDLE with busy=0.
- Counter width: 32 bits. The product beats*BEAT_TICKS is computed at 32 bits and never truncated (15*BEAT_TICKS max).
- stop=1 in any non-IDLE state: the next state is IDLE, tone_en=0, note_divisor=0, note_idx=0, and no done pulse.
- Simultaneous events:
  - start and stop both high while IDLE: stop wins, remain IDLE.
  - start while busy: ignored (no restart).
- loop changing mid-song takes effect at the next end-marker LOAD.
- Reset mid-playback behaves like stop, but also clears done.

Test Plan (bench overrides BEAT_TICKS=10, GAP_TICKS=2):
- Reset with rst_n=0 for 3 cycles, then release: all outputs 0, busy=0. After 5 further idle cycles, outputs are unchanged.
- Pulse start for 1 cycle (sampled at edge 0): LOAD after edge 0; from edge 1, note_divisor=190840 with tone_en=1 for 8 cycles, then tone_en=0 for 2 cycles; note_idx=1 after edge 11.
- Full song with loop=0: entry 6 (sol, 2 beats) has tone_en high for 18 cycles; entry 14 (rest) keeps tone_en=0 and divisor=0 for 20 cycles; done=1 for exactly one cycle, in the state after edge 196; busy=0 afterwards.
- Full song with loop=1: no done pulse; note_idx returns to 0 and note_divisor=190840 again 1 cycle after the end-marker LOAD; the song repeats for 2 iterations.
- Assert stop during entry 3 PLAY: the next cycle shows IDLE, tone_en=0, note_divisor=0, note_idx=0, busy=0, and no done pulse. A later start restarts from entry 0.
- Pulse start again at entry 2: ignored, timing unchanged. Drive start and stop together while idle: remains IDLE. Assert rst_n=0 mid-note: all outputs are 0 after the next edge.
